// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: default Galois tap masks per width and a width-generic
// single-step helper used by the advance unroll.
package lfsr_pkg;

   localparam logic [2:0]  TAPS_3  = 3'h3;
   localparam logic [3:0]  TAPS_4  = 4'h3;
   localparam logic [7:0]  TAPS_8  = 8'h1D;
   localparam logic [15:0] TAPS_16 = 16'h4003;
   localparam logic [31:0] TAPS_32 = 32'h0040_0007;

   // Operates on a 32-bit container; bits at and above w are forced to zero.
   function automatic logic [31:0] galois_step(input logic [31:0] s,
                                               input logic [31:0] taps,
                                               input int unsigned w);
      logic [31:0] mask;
      logic        msb;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      msb  = |(s & (32'd1 << (w - 1)));
      return ((s << 1) ^ (msb ? taps : '0)) & mask;
   endfunction

endpackage

// File: rtl/lfsr_galois_adv.sv
// Combinational STEPS-fold Galois advance of a WIDTH-bit LFSR state.
module lfsr_galois_adv
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
   parameter int unsigned      STEPS = 1
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] adv_o
);

   localparam logic [31:0] TAPS32 = 32'(TAPS);

   logic [31:0] acc;

   always_comb begin
      acc = 32'(state_i);
      for (int unsigned i = 0; i < STEPS; i++) begin
         acc = galois_step(acc, TAPS32, WIDTH);
      end
      adv_o = acc[WIDTH-1:0];
   end

endmodule

// File: rtl/lfsr_stream.sv
// Galois LFSR word generator with valid/ready output, seed loading with
// zero-seed substitution, and period-wrap detection.
module lfsr_stream
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
   parameter int unsigned      STEPS        = 1,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             en_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             out_ready_in,
   output logic             out_valid_out,
   output logic [WIDTH-1:0] out_data_out,
   output logic             wrap_out,
   output logic [WIDTH-1:0] period_out
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] adv;
   logic [WIDTH-1:0] seed_eff;
   logic             xfer;

   lfsr_galois_adv #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .STEPS (STEPS)
   ) u_adv (
      .state_i (state_q),
      .adv_o   (adv)
   );

   assign seed_eff = (seed_in == '0) ? DEFAULT_SEED : seed_in;
   assign xfer     = valid_q & out_ready_in;

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      count_d  = count_q;
      period_d = period_q;
      wrap_d   = 1'b0;
      valid_d  = en_in & ~load_in;
      // Load wins over a handshake on the same cycle; valid drops so the old
      // word is never paired with the new seed.
      if (load_in) begin
         state_d = seed_eff;
         start_d = seed_eff;
         count_d = '0;
      end else if (xfer) begin
         state_d = adv;
         if (adv == start_q) begin
            wrap_d   = 1'b1;
            period_d = count_q + 1'b1;
            count_d  = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= DEFAULT_SEED;
         start_q  <= DEFAULT_SEED;
         count_q  <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         count_q  <= count_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         wrap_q   <= wrap_d;
      end
   end

   assign out_valid_out = valid_q;
   assign out_data_out  = state_q;
   assign wrap_out      = wrap_q;
   assign period_out    = period_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream: default 16-bit instance under random
// backpressure/loads/reset, a 4-bit full-period instance and a STEPS=4 instance.
module tb_lfsr_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Spec rule as arithmetic: double the value; on overflow drop 2^w and XOR taps.
   function automatic logic [31:0] ref_step(input int unsigned w, input logic [31:0] taps,
                                            input logic [31:0] s);
      longint unsigned m, d;
      m = longint'(1) << w;
      d = longint'(s) * 2;
      if (d >= m) return 32'(d - m) ^ taps;
      return 32'(d);
   endfunction

   // ---------------- main 16-bit instance ----------------
   logic        rst, en, load, ready;
   logic [15:0] seed;
   logic        valid0, wrap0;
   logic [15:0] data0, period0;

   lfsr_stream u0 (
      .clk_in(clk), .rst_in(rst), .en_in(en), .load_in(load), .seed_in(seed),
      .out_ready_in(ready), .out_valid_out(valid0), .out_data_out(data0),
      .wrap_out(wrap0), .period_out(period0)
   );

   // ---------------- secondary instances, free-running ----------------
   logic       rst_b, en_b, ready_b;
   logic       valid4, wrap4;
   logic [3:0] data4, period4;
   logic       valid_s, wrap_s;
   logic [15:0] data_s, period_s;

   lfsr_stream #(.WIDTH(4), .TAPS(4'h3), .STEPS(1), .DEFAULT_SEED(4'h1)) u4 (
      .clk_in(clk), .rst_in(rst_b), .en_in(en_b), .load_in(1'b0), .seed_in(4'h0),
      .out_ready_in(ready_b), .out_valid_out(valid4), .out_data_out(data4),
      .wrap_out(wrap4), .period_out(period4)
   );

   lfsr_stream #(.STEPS(4)) us4 (
      .clk_in(clk), .rst_in(rst_b), .en_in(en_b), .load_in(1'b0), .seed_in(16'h0),
      .out_ready_in(ready_b), .out_valid_out(valid_s), .out_data_out(data_s),
      .wrap_out(wrap_s), .period_out(period_s)
   );

   // ---------------- u0 scoreboard ----------------
   logic [15:0] exp_q[$];
   int unsigned acc0 = 0;

   task automatic fill_q(input logic [15:0] s0);
      logic [31:0] s;
      exp_q.delete();
      s = 32'(s0);
      repeat (400) begin
         exp_q.push_back(s[15:0]);
         s = ref_step(16, 32'h4003, s);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && valid0) begin
         if (exp_q.size() == 0) chk("u0_queue_empty", 32'd1, 32'd0);
         else begin
            chk("u0_data", 32'(data0), 32'(exp_q[0]));
            if (ready) begin
               void'(exp_q.pop_front());
               acc0++;
            end
         end
      end
   end

   // ---------------- u4 full-period monitor ----------------
   logic [31:0] m4 = 32'd1;
   logic        exp_wrap4 = 1'b0;
   logic [31:0] exp_per4 = 32'd0;
   int unsigned cnt4 = 0;
   int unsigned n4 = 0;
   logic [15:0] seen4 = '0;
   int unsigned distinct4 = 0;

   always @(negedge clk) begin
      logic [31:0] n;
      if (!rst_b) begin
         chk("u4_wrap", 32'(wrap4), 32'(exp_wrap4));
         chk("u4_period", 32'(period4), exp_per4);
         exp_wrap4 = 1'b0;
         if (valid4 && ready_b) begin
            chk("u4_data", 32'(data4), m4);
            if (n4 < 15 && !seen4[data4]) begin
               seen4[data4] = 1'b1;
               distinct4++;
            end
            n4++;
            n = ref_step(4, 32'h3, m4);
            if (n == 32'd1) begin
               exp_wrap4 = 1'b1;
               exp_per4  = 32'(cnt4 + 1);
               cnt4      = 0;
            end else cnt4++;
            m4 = n;
         end
      end
   end

   // ---------------- STEPS=4 monitor ----------------
   logic [31:0] ms = 32'd1;
   int unsigned ns = 0;

   always @(negedge clk) begin
      if (!rst_b && valid_s && ready_b) begin
         chk("s4_data", 32'(data_s), ms);
         for (int k = 0; k < 4; k++) ms = ref_step(16, 32'h4003, ms);
         ns++;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; rst_b = 1'b1; en = 1'b0; load = 1'b0; ready = 1'b0; seed = '0;
      en_b = 1'b0; ready_b = 1'b0;
      #12;
      chk("rst_data", 32'(data0), 32'h0001);
      chk("rst_valid", 32'(valid0), 32'd0);
      chk("rst_wrap", 32'(wrap0), 32'd0);
      chk("rst_period", 32'(period0), 32'd0);

      @(posedge clk); #1;
      rst = 1'b0; rst_b = 1'b0;
      fill_q(16'h0001);
      en = 1'b1; ready = 1'b1; en_b = 1'b1; ready_b = 1'b1;
      @(negedge clk);
      chk("valid_before_edge", 32'(valid0), 32'd0);
      @(negedge clk);
      chk("valid_after_en", 32'(valid0), 32'd1);
      repeat (20) @(posedge clk);

      // random backpressure and enable gaps
      repeat (200) begin
         @(posedge clk); #1;
         ready = ($urandom % 100) < 60;
         en    = ($urandom % 100) < 90;
      end
      @(posedge clk); #1; en = 1'b1; ready = 1'b1;
      repeat (3) @(posedge clk);

      // zero seed is substituted
      #1; load = 1'b1; seed = 16'h0000; ready = 1'b0;
      @(posedge clk); #1; load = 1'b0; ready = 1'b1;
      fill_q(16'h0001);
      @(negedge clk);
      chk("load0_data", 32'(data0), 32'h0001);
      chk("load0_valid", 32'(valid0), 32'd0);
      repeat (10) @(posedge clk);

      // explicit seed
      #1; load = 1'b1; seed = 16'hBEEF; ready = 1'b0;
      @(posedge clk); #1; load = 1'b0; ready = 1'b1;
      fill_q(16'hBEEF);
      @(negedge clk);
      chk("loadBEEF_data", 32'(data0), 32'hBEEF);
      chk("loadBEEF_valid", 32'(valid0), 32'd0);
      repeat (20) @(posedge clk);

      // asynchronous reset between edges, mid-handshake
      #3; rst = 1'b1;
      #1;
      chk("arst_data", 32'(data0), 32'h0001);
      chk("arst_valid", 32'(valid0), 32'd0);
      chk("arst_wrap", 32'(wrap0), 32'd0);
      chk("arst_period", 32'(period0), 32'd0);
      exp_q.delete();
      @(posedge clk); #1; rst = 1'b0;
      fill_q(16'h0001);
      repeat (30) @(posedge clk);

      chk("u0_accepts_min", 32'(acc0 >= 100), 32'd1);
      chk("u4_distinct15", 32'(distinct4), 32'd15);
      chk("u4_final_period", 32'(period4), 32'd15);
      chk("s4_accepts_min", 32'(ns >= 100), 32'd1);

      @(negedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
